// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational 8-bit ALU between two
// valid/ready requesters, with operand/result registers and a divide-by-zero trap.
module alu_share_ctrl #(
    parameter logic       RR_INIT     = 1'b0,
    parameter logic [7:0] DIV0_RESULT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req1_op,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,
    output logic       rsp0_carry,
    output logic       rsp0_err,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,
    output logic       rsp1_carry,
    output logic       rsp1_err,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d, owner_q, owner_d;
    logic [7:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [3:0] op_q, op_d;
    logic       carry_q, carry_d, err_q, err_d;
    logic       grant, div0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= RR_INIT;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        req0_ready = (state_q == IDLE) && req0_valid && !grant;
        req1_ready = (state_q == IDLE) && req1_valid && grant;
        div0       = (op_q == 4'b0011) && (b_q == 8'd0);
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        data_d     = data_q;
        carry_d    = carry_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (req0_ready || req1_ready) begin
                state_d = EXEC;
                owner_d = grant;
                a_d     = grant ? req1_a : req0_a;
                b_d     = grant ? req1_b : req0_b;
                op_d    = grant ? req1_op : req0_op;
            end
            EXEC: begin
                state_d = RESP;
                data_d  = div0 ? DIV0_RESULT : alu_out;
                err_d   = div0;
                carry_d = (op_q == 4'b0000) ? alu_carry : 1'b0;
            end
            RESP: if (owner_q ? rsp1_ready : rsp0_ready) begin
                state_d = IDLE;
                ptr_d   = !owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_data  = data_q;
    assign rsp1_data  = data_q;
    assign rsp0_carry = carry_q;
    assign rsp1_carry = carry_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = op_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl with a small behavioural ALU
// whose carry is deliberately set on non-add ops so carry masking is observable.
module tb_alu_share_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [7:0] rsp0_data, rsp1_data;
    logic       rsp0_carry, rsp1_carry, rsp0_err, rsp1_err;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry, busy;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.RR_INIT(1'b0), .DIV0_RESULT(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_carry(rsp0_carry), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_carry(rsp1_carry), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
    );

    always_comb begin
        alu_out   = alu_a ^ alu_b;
        alu_carry = 1'b1;
        case (alu_sel)
            4'b0000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0011: alu_out = (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
            4'b1110: alu_out = alu_a & alu_b;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; returns on the negedge after the response is taken.
    task automatic run_op(input int n, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input logic [7:0] ed, input logic ec, input logic ee, input string tag);
        bit got = 0;
        @(posedge clk); #1;
        if (n == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        else begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (n == 0) ? req0_ready : req1_ready;
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
        chk({tag, "_exec_novalid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'({rsp1_valid, rsp0_valid}), (n == 0) ? 32'd1 : 32'd2);
        chk({tag, "_data"}, 32'((n == 0) ? rsp0_data : rsp1_data), 32'(ed));
        chk({tag, "_carry"}, 32'((n == 0) ? rsp0_carry : rsp1_carry), 32'(ec));
        chk({tag, "_err"}, 32'((n == 0) ? rsp0_err : rsp1_err), 32'(ee));
        if (n == 0) rsp0_ready = 1; else rsp1_ready = 1;
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_data", 32'(rsp0_data), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("rst_flags", 32'({rsp0_carry, rsp0_err, rsp1_carry, rsp1_err}), 32'd0);
        @(negedge clk); rst_n = 1;

        run_op(0, 8'd200, 8'd100, 4'b0000, 8'd44, 1'b1, 1'b0, "add");
        run_op(1, 8'd7, 8'd0, 4'b0011, 8'hFF, 1'b0, 1'b1, "div0");
        run_op(1, 8'd9, 8'd3, 4'b0011, 8'd3, 1'b0, 1'b0, "div");

        // Contention: ptr is 0 after req1's last op, so grants run 0,1,0,1,0,1.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd10; req0_b = 8'd20; req0_op = 4'b0000;
        req1_valid = 1; req1_a = 8'd9;  req1_b = 8'd4;  req1_op = 4'b0001;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_ready", k), 32'({req1_ready, req0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            chk($sformatf("rr%0d_exec", k), 32'({req1_ready, req0_ready, rsp1_valid, rsp0_valid}), 32'd0);
            @(negedge clk);
            chk($sformatf("rr%0d_valid", k), 32'({rsp1_valid, rsp0_valid}), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_data", k), 32'(rsp0_data), (k % 2 == 0) ? 32'd30 : 32'd5);
        end
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        rsp0_ready = 0; rsp1_ready = 0;

        // Back-pressure on rsp0 while req1 waits.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 8'd50; req0_b = 8'd60; req0_op = 4'b0000;
        @(negedge clk);
        chk("bp_accept0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 1; req1_a = 8'd100; req1_b = 8'd200; req1_op = 4'b0000;
        @(negedge clk);
        chk("bp_exec_r1", 32'(req1_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_hold", k), 32'({rsp0_valid, rsp1_valid, busy, req1_ready}), 32'b1010);
            chk($sformatf("bp%0d_data", k), 32'(rsp0_data), 32'd110);
        end
        rsp0_ready = 1;
        @(posedge clk); #1;
        rsp0_ready = 0;
        @(negedge clk);
        chk("bp_r1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_r1_valid", 32'({rsp1_valid, rsp0_valid}), 32'd2);
        chk("bp_r1_data", 32'({rsp1_carry, rsp1_data}), {23'd0, 1'b1, 8'd44});
        rsp1_ready = 1;
        @(posedge clk); #1;
        rsp1_ready = 0;

        run_op(0, 8'd5, 8'd3, 4'b0001, 8'd2, 1'b0, 1'b0, "sub");
        run_op(0, 8'hFF, 8'h01, 4'b1110, 8'd1, 1'b0, 1'b0, "and");

        // Reset during RESP of a req1 op; ptr was 1 and must return to RR_INIT.
        @(posedge clk); #1;
        req1_valid = 1; req1_a = 8'd1; req1_b = 8'd2; req1_op = 4'b0000;
        @(negedge clk);
        chk("rr_pre_ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_pre_valid", 32'(rsp1_valid), 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_data", 32'(rsp1_data), 32'd0);
        chk("rst_mid_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(negedge clk); rst_n = 1;
        req0_valid = 1; req0_a = 8'd3; req0_b = 8'd4; req0_op = 4'b0000;
        req1_valid = 1; req1_a = 8'd8; req1_b = 8'd8; req1_op = 4'b0000;
        #1;
        chk("rst_ptr", 32'({req1_ready, req0_ready}), 32'd1);
        req0_valid = 0; req1_valid = 0;
        run_op(1, 8'd8, 8'd8, 4'b0000, 8'd16, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
